// File: rtl/ctrl_pkg.sv
// Purpose: shared types and encodings for the RV32I multi-cycle controller.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
//
// Contents: state_e, alu_op_e, opcode constants, mux-select constants, funct3_op().
package ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd7
   } state_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [1:0] SRC_A_RS1  = 2'd0;
   localparam logic [1:0] SRC_A_PC   = 2'd1;
   localparam logic [1:0] SRC_A_ZERO = 2'd2;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_LINK = 2'd2;

   // alt selects the alternate operation (SUB for 000, SRA for 101);
   // callers decide when alt is meaningful.
   function automatic alu_op_e funct3_op(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Purpose: maps opcode/funct3/funct7 to an ALU operation and a legality flag.
// Latency: combinational.
// Backpressure: none.
//
// Ports: opcode, funct3, funct7 in; alu_op (ALU op for the EXEC step), legal out.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output alu_op_e    alu_op,
   output logic       legal
);

   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b0;
      case (opcode)
         OP_R: begin
            // Only base RV32I R-type: funct7 all zero, or SUB/SRA.
            legal  = (funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            alu_op = funct3_op(funct3, funct7[5]);
         end
         OP_IALU: begin
            // imm[10] shares the funct7[5] position; it only means SRA for shifts.
            legal  = 1'b1;
            alu_op = funct3_op(funct3, (funct3 == 3'b101) && funct7[5]);
         end
         OP_LOAD, OP_STORE: begin
            legal  = (funct3 == 3'b010);
            alu_op = ALU_ADD;
         end
         OP_BRANCH: begin
            legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
            alu_op = ALU_SUB;
         end
         OP_JAL, OP_LUI: begin
            legal  = 1'b1;
            alu_op = ALU_ADD;
         end
         default: begin
            legal  = 1'b0;
            alu_op = ALU_ADD;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Latency: branch 3, R/I/LUI/JAL 4, SW 4+waits, LW 5+waits cycles per instruction.
// Backpressure: MEM holds the request until mem_ready; MEM_TIMEOUT waiting cycles traps.
//
// Ports: clk, reset (async, active low), inst, zero, mem_ready in;
//        pc_wr, pc_src, ir_wr, reg_wr, mem_rd, mem_wr, alu_op, alu_src_a, alu_src_b,
//        wb_sel, illegal, bus_err, instret, state_dbg out.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      inst,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_wr,
   output logic             pc_src,
   output logic             ir_wr,
   output logic             reg_wr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [3:0]       alu_op,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       wb_sel,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state_dbg
);

   localparam int                TMO_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   state_e           state;
   logic [TMO_W-1:0] tmo_cnt;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   alu_op_e    dec_op;
   logic       dec_legal;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   // Register and immediate fields are the datapath's business.
   logic unused_inst_bits;
   assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

   logic is_load, is_store, is_branch, is_jal, is_lui, is_r, is_ialu, taken;

   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_lui    = (opcode == OP_LUI);
   assign is_r      = (opcode == OP_R);
   assign is_ialu   = (opcode == OP_IALU);
   // funct3[0] distinguishes BNE (001) from BEQ (000).
   assign taken     = is_branch && (funct3[0] ? !zero : zero);

   alu_decoder u_alu_decoder (
      .opcode (opcode),
      .funct3 (funct3),
      .funct7 (funct7),
      .alu_op (dec_op),
      .legal  (dec_legal)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= FETCH;
         instret <= '0;
         tmo_cnt <= '0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         case (state)
            FETCH: state <= DECODE;
            DECODE: begin
               if (!dec_legal) begin
                  state   <= TRAP;
                  illegal <= 1'b1;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (is_branch) begin
                  state   <= FETCH;
                  instret <= instret + CNT_W'(1);
               end else if (is_load || is_store) begin
                  state <= MEM;
               end else begin
                  state <= WB;
               end
            end
            MEM: begin
               if (mem_ready) begin
                  tmo_cnt <= '0;
                  if (is_store) begin
                     state   <= FETCH;
                     instret <= instret + CNT_W'(1);
                  end else begin
                     state <= WB;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  // This was the MEM_TIMEOUT-th unanswered cycle.
                  state   <= TRAP;
                  bus_err <= 1'b1;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            WB: begin
               state   <= FETCH;
               instret <= instret + CNT_W'(1);
            end
            TRAP:    state <= TRAP;
            default: state <= TRAP;
         endcase
      end
   end

   logic    pc_wr_c, ir_wr_c, reg_wr_c, mem_rd_c, mem_wr_c;
   alu_op_e alu_op_c;

   always_comb begin
      pc_wr_c   = 1'b0;
      pc_src    = 1'b0;
      ir_wr_c   = 1'b0;
      reg_wr_c  = 1'b0;
      mem_rd_c  = 1'b0;
      mem_wr_c  = 1'b0;
      alu_op_c  = ALU_ADD;
      alu_src_a = SRC_A_RS1;
      alu_src_b = SRC_B_RS2;
      wb_sel    = WB_ALU;
      case (state)
         FETCH: begin
            ir_wr_c   = 1'b1;
            pc_wr_c   = 1'b1;
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_FOUR;
            alu_op_c  = ALU_ADD;
         end
         EXEC: begin
            alu_op_c = dec_op;
            if (is_ialu || is_load || is_store) begin
               alu_src_b = SRC_B_IMM;
            end else if (is_lui) begin
               alu_src_a = SRC_A_ZERO;
               alu_src_b = SRC_B_IMM;
            end else if (is_branch) begin
               pc_wr_c = taken;
               pc_src  = taken;
            end else if (is_jal) begin
               pc_wr_c = 1'b1;
               pc_src  = 1'b1;
            end else begin
               // R-type uses the rs1/rs2 defaults.
               alu_src_b = SRC_B_RS2;
            end
         end
         MEM: begin
            mem_rd_c = is_load;
            mem_wr_c = is_store;
         end
         WB: begin
            reg_wr_c = 1'b1;
            wb_sel   = is_load ? WB_MEM : (is_jal ? WB_LINK : WB_ALU);
         end
         default: ;
      endcase
   end

   // Writes and requests are gated directly by reset so they drop
   // immediately on assertion, independent of any clock edge.
   assign pc_wr     = pc_wr_c  & reset;
   assign ir_wr     = ir_wr_c  & reset;
   assign reg_wr    = reg_wr_c & reset;
   assign mem_rd    = mem_rd_c & reset;
   assign mem_wr    = mem_wr_c & reset;
   assign alu_op    = alu_op_c;
   assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose: scoreboard bench for multicycle_controller with directed instruction vectors.
// Latency: one expected output vector per clock cycle, checked on the falling edge.
// Backpressure: mem_ready driven per cycle from the stimulus table.
module tb_multicycle_controller;

   localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_T = 7;

   typedef struct packed {
      logic [2:0]  st;
      logic        pcw, pcs, irw, rw, mr, mw;
      logic [3:0]  op;
      logic [1:0]  a, b, wb;
      logic        ill, be;
      logic [31:0] n;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, zero, mem_ready;
   logic [31:0] inst, cur_inst;
   logic        pc_wr, pc_src, ir_wr, reg_wr, mem_rd, mem_wr, illegal, bus_err;
   logic [3:0]  alu_op;
   logic [1:0]  alu_src_a, alu_src_b, wb_sel;
   logic [31:0] instret;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_err    = 0;

   exp_t  q_exp[$];
   string q_name[$];

   multicycle_controller #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .inst(inst), .zero(zero), .mem_ready(mem_ready),
      .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .reg_wr(reg_wr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
      .instret(instret), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic exp_t E(int st, int pcw, int pcs, int irw, int rw, int mr, int mw,
                              int op, int a, int b, int wb, int ill, int be, int n);
      exp_t r;
      r.st  = 3'(st);  r.pcw = 1'(pcw); r.pcs = 1'(pcs); r.irw = 1'(irw);
      r.rw  = 1'(rw);  r.mr  = 1'(mr);  r.mw  = 1'(mw);  r.op  = 4'(op);
      r.a   = 2'(a);   r.b   = 2'(b);   r.wb  = 2'(wb);  r.ill = 1'(ill);
      r.be  = 1'(be);  r.n   = 32'(n);
      return r;
   endfunction

   // Hand-written per-state shapes of the expected outputs.
   function automatic exp_t FE(int n);  return E(S_F,1,0,1,0,0,0, 0,1,2,0, 0,0, n); endfunction
   function automatic exp_t DE(int n);  return E(S_D,0,0,0,0,0,0, 0,0,0,0, 0,0, n); endfunction
   function automatic exp_t RS();       return E(S_F,0,0,0,0,0,0, 0,1,2,0, 0,0, 0); endfunction
   function automatic exp_t EXE(int pcw, int pcs, int op, int a, int b, int n);
      return E(S_E,pcw,pcs,0,0,0,0, op,a,b,0, 0,0, n);
   endfunction
   function automatic exp_t ME(int mr, int mw, int n); return E(S_M,0,0,0,0,mr,mw, 0,0,0,0, 0,0, n); endfunction
   function automatic exp_t WBE(int wb, int n);        return E(S_W,0,0,0,1,0,0, 0,0,0,wb, 0,0, n); endfunction
   function automatic exp_t TR(int ill, int be, int n); return E(S_T,0,0,0,0,0,0, 0,0,0,0, ill,be, n); endfunction

   function automatic string fmt(exp_t r);
      return $sformatf("st=%0d pcw=%b pcs=%b irw=%b rw=%b mr=%b mw=%b op=%0d a=%0d b=%0d wb=%0d ill=%b be=%b n=%0d",
                       r.st, r.pcw, r.pcs, r.irw, r.rw, r.mr, r.mw, r.op, r.a, r.b, r.wb, r.ill, r.be, r.n);
   endfunction

   function automatic exp_t act_now();
      exp_t r;
      r.st = state_dbg; r.pcw = pc_wr; r.pcs = pc_src; r.irw = ir_wr; r.rw = reg_wr;
      r.mr = mem_rd; r.mw = mem_wr; r.op = alu_op; r.a = alu_src_a; r.b = alu_src_b;
      r.wb = wb_sel; r.ill = illegal; r.be = bus_err; r.n = instret;
      return r;
   endfunction

   task automatic check(input string nm, input exp_t got, input exp_t want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got %s want %s", nm, fmt(got), fmt(want));
      end
   endtask

   // Drive one cycle's inputs and queue the outputs expected during that cycle.
   task automatic step(input string nm, input int rs, input int mr, input int z, input exp_t e);
      @(posedge clk);
      #1;
      reset     = (rs != 0);
      mem_ready = (mr != 0);
      zero      = (z != 0);
      inst      = cur_inst;
      q_exp.push_back(e);
      q_name.push_back(nm);
   endtask

   // Monitor: consumes one expectation per falling edge while any are pending.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (q_exp.size() != 0) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            check(nm, act_now(), e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired with %0d expectations pending", q_exp.size());
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; zero = 1'b0; mem_ready = 1'b0; inst = '0; cur_inst = '0;

      step("rst_a", 0,0,0, RS());
      step("rst_b", 0,0,0, RS());

      cur_inst = 32'h002081B3;                       // add x3,x1,x2
      step("add_f", 1,0,0, FE(0));
      step("add_d", 1,0,0, DE(0));
      step("add_e", 1,0,0, EXE(0,0,0,0,0,0));
      step("add_w", 1,0,0, WBE(0,0));

      cur_inst = 32'h402081B3;                       // sub
      step("sub_f", 1,0,0, FE(1));
      step("sub_d", 1,0,0, DE(1));
      step("sub_e", 1,0,0, EXE(0,0,1,0,0,1));
      step("sub_w", 1,0,0, WBE(0,1));

      cur_inst = 32'h4020D093;                       // srai x1,x1,2
      step("srai_f", 1,0,0, FE(2));
      step("srai_d", 1,0,0, DE(2));
      step("srai_e", 1,0,0, EXE(0,0,7,0,1,2));
      step("srai_w", 1,0,0, WBE(0,2));

      cur_inst = 32'h0000A283;                       // lw x5,0(x1); ready ignored before MEM
      step("lw_f", 1,0,0, FE(3));
      step("lw_d", 1,1,0, DE(3));
      step("lw_e", 1,1,0, EXE(0,0,0,0,1,3));
      for (int i = 0; i < 3; i++) step("lw_mwait", 1,0,0, ME(1,0,3));
      step("lw_mrdy", 1,1,0, ME(1,0,3));
      step("lw_w", 1,0,0, WBE(1,3));

      cur_inst = 32'h0020A023;                       // sw, zero-wait
      step("sw0_f", 1,0,0, FE(4));
      step("sw0_d", 1,0,0, DE(4));
      step("sw0_e", 1,0,0, EXE(0,0,0,0,1,4));
      step("sw0_m", 1,1,0, ME(0,1,4));

      cur_inst = 32'h00000463;                       // beq x0,x0,8
      step("beqt_f", 1,0,1, FE(5));
      step("beqt_d", 1,0,1, DE(5));
      step("beqt_e", 1,0,1, EXE(1,1,1,0,0,5));
      step("beqn_f", 1,0,0, FE(6));
      step("beqn_d", 1,0,0, DE(6));
      step("beqn_e", 1,0,0, EXE(0,0,1,0,0,6));

      cur_inst = 32'h00001463;                       // bne x0,x0,8
      step("bnen_f", 1,0,1, FE(7));
      step("bnen_d", 1,0,1, DE(7));
      step("bnen_e", 1,0,1, EXE(0,0,1,0,0,7));
      step("bnet_f", 1,0,0, FE(8));
      step("bnet_d", 1,0,0, DE(8));
      step("bnet_e", 1,0,0, EXE(1,1,1,0,0,8));

      cur_inst = 32'h008000EF;                       // jal x1,8
      step("jal_f", 1,0,0, FE(9));
      step("jal_d", 1,0,0, DE(9));
      step("jal_e", 1,0,0, EXE(1,1,0,0,0,9));
      step("jal_w", 1,0,0, WBE(2,9));

      cur_inst = 32'h123450B7;                       // lui x1,0x12345
      step("lui_f", 1,0,0, FE(10));
      step("lui_d", 1,0,0, DE(10));
      step("lui_e", 1,0,0, EXE(0,0,0,2,1,10));
      step("lui_w", 1,0,0, WBE(0,10));

      cur_inst = 32'hFFFFFFFF;                       // illegal opcode
      step("ill_f", 1,0,0, FE(11));
      step("ill_d", 1,0,0, DE(11));
      for (int i = 0; i < 3; i++) step("ill_trap", 1,1,1, TR(1,0,11));
      step("ill_rst_a", 0,0,0, RS());
      step("ill_rst_b", 0,0,0, RS());

      cur_inst = 32'h40000093;                       // addi x1,x0,0x400: never SUB
      step("addi_f", 1,0,0, FE(0));
      step("addi_d", 1,0,0, DE(0));
      step("addi_e", 1,0,0, EXE(0,0,0,0,1,0));
      step("addi_w", 1,0,0, WBE(0,0));

      cur_inst = 32'h0020A023;                       // sw with no mem_ready: timeout
      step("swto_f", 1,0,0, FE(1));
      step("swto_d", 1,0,0, DE(1));
      step("swto_e", 1,0,0, EXE(0,0,0,0,1,1));
      for (int i = 0; i < 8; i++) step("swto_m", 1,0,0, ME(0,1,1));
      for (int i = 0; i < 2; i++) step("swto_trap", 1,0,0, TR(0,1,1));
      step("swto_trap_rdy", 1,1,0, TR(0,1,1));
      step("swto_rst", 0,0,0, RS());

      step("swar_f", 1,0,0, FE(0));                  // reset asserted mid-MEM
      step("swar_d", 1,0,0, DE(0));
      step("swar_e", 1,0,0, EXE(0,0,0,0,1,0));
      step("swar_m0", 1,0,0, ME(0,1,0));
      step("swar_m1", 1,0,0, ME(0,1,0));
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_mid_mem", act_now(), RS());
      step("swar_hold", 0,0,0, RS());

      @(negedge clk);
      #1;
      n_checks++;
      if (q_exp.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain got %0d pending want 0", q_exp.size());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
